// File: rtl/ql_ram_arb.sv
// rtl/ql_ram_arb.sv - three-way SDRAM port arbiter (video, CPU, microdrive) with starvation guard and watchdog
module ql_ram_arb #(
  parameter int MDV_MAX_WAIT = 8,
  parameter int TIMEOUT      = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic        vid_ack,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [24:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,
  input  logic        mdv_req,
  input  logic [24:0] mdv_addr,
  output logic        mdv_ack,
  output logic [15:0] ram_data,
  output logic        video_cycle,
  output logic        timeout_err,
  output logic        sd_start,
  output logic [24:0] sd_addr,
  output logic        sd_we,
  output logic [1:0]  sd_ds,
  output logic [15:0] sd_dout,
  input  logic [15:0] sd_din,
  input  logic        sd_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [1:0] OWN_VID = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_MDV = 2'd2;

  localparam logic [3:0] MDV_LIM = MDV_MAX_WAIT[3:0];
  localparam logic [3:0] TO_LIM  = TIMEOUT[3:0];

  logic [1:0] state;
  logic [1:0] owner;
  logic [1:0] grant;
  logic [3:0] starve_cnt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_next;
  logic       starved;
  logic       any_req;

  assign starved   = (starve_cnt >= MDV_LIM);
  assign any_req   = vid_req | cpu_req | mdv_req;
  assign wait_next = wait_cnt + 4'd1;

  always_comb begin
    grant = OWN_MDV;
    if (vid_req)
      grant = OWN_VID;
    else if (mdv_req && starved)
      grant = OWN_MDV;
    else if (cpu_req)
      grant = OWN_CPU;
  end

  // Ack, data and timeout flag are all loaded on the edge into DONE so they coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_VID;
      wait_cnt    <= 4'd0;
      ram_data    <= 16'h0000;
      video_cycle <= 1'b0;
      timeout_err <= 1'b0;
      sd_start    <= 1'b0;
      sd_addr     <= 25'd0;
      sd_we       <= 1'b0;
      sd_ds       <= 2'b11;
      sd_dout     <= 16'h0000;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      mdv_ack     <= 1'b0;
    end else begin
      sd_start    <= 1'b0;
      timeout_err <= 1'b0;
      vid_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      mdv_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner       <= grant;
            video_cycle <= (grant == OWN_VID);
            sd_start    <= 1'b1;
            state       <= ISSUE;
            case (grant)
              OWN_VID: begin
                sd_addr <= vid_addr;
                sd_we   <= 1'b0;
                sd_ds   <= 2'b00;
              end
              OWN_CPU: begin
                sd_addr <= cpu_addr;
                sd_we   <= cpu_wr;
                sd_ds   <= cpu_ds;
                sd_dout <= cpu_din;
              end
              default: begin
                sd_addr <= mdv_addr;
                sd_we   <= 1'b0;
                sd_ds   <= 2'b00;
              end
            endcase
          end
        end
        ISSUE: begin
          wait_cnt <= 4'd0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_next;
          if (sd_done || (wait_next == TO_LIM)) begin
            if (!sd_done) begin
              ram_data    <= 16'hFFFF;
              timeout_err <= 1'b1;
            end else if (!sd_we) begin
              ram_data <= sd_din;
            end
            vid_ack <= (owner == OWN_VID);
            cpu_ack <= (owner == OWN_CPU);
            mdv_ack <= (owner == OWN_MDV);
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Counts clocks an mdv request spends waiting behind other owners.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      starve_cnt <= 4'd0;
    else if (!mdv_req || mdv_ack)
      starve_cnt <= 4'd0;
    else if ((owner != OWN_MDV) && (starve_cnt != 4'd15))
      starve_cnt <= starve_cnt + 4'd1;
  end

endmodule

// File: tb/tb_ql_ram_arb.sv
// tb/tb_ql_ram_arb.sv - directed and random checks of ql_ram_arb against a transaction-level model
module tb_ql_ram_arb;
  localparam int MDV_MAX_WAIT = 8;
  localparam int TIMEOUT      = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0;
  logic [24:0] vid_addr = '0;
  logic        vid_ack;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [1:0]  cpu_ds = 2'b11;
  logic [15:0] cpu_din = '0;
  logic        cpu_ack;
  logic        mdv_req = 1'b0;
  logic [24:0] mdv_addr = '0;
  logic        mdv_ack;
  logic [15:0] ram_data;
  logic        video_cycle;
  logic        timeout_err;
  logic        sd_start;
  logic [24:0] sd_addr;
  logic        sd_we;
  logic [1:0]  sd_ds;
  logic [15:0] sd_dout;
  logic [15:0] sd_din = '0;
  logic        sd_done = 1'b0;

  ql_ram_arb #(.MDV_MAX_WAIT(MDV_MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .mdv_req(mdv_req), .mdv_addr(mdv_addr), .mdv_ack(mdv_ack),
    .ram_data(ram_data), .video_cycle(video_cycle), .timeout_err(timeout_err),
    .sd_start(sd_start), .sd_addr(sd_addr), .sd_we(sd_we), .sd_ds(sd_ds),
    .sd_dout(sd_dout), .sd_din(sd_din), .sd_done(sd_done)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Model: 0 = video, 1 = cpu, 2 = mdv
  bit          idle_m, done_c, to_c, ack_nxt, to_nxt, pend, vc_m, acc_wr;
  bit          rnd_drive, stray_en;
  bit          hold [3];
  int          cnt, owner_m, wait_k, lat, force_lat, force_data, n_to;
  int          n_ack [3];
  int          grants [$];
  logic [15:0] exp_ram, rdata;
  logic        last_we;
  logic [1:0]  last_ds;
  logic [15:0] last_dout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit quiet();
    return !vid_req && !cpu_req && !mdv_req && !pend && !ack_nxt && !done_c && idle_m;
  endfunction

  task automatic model_init();
    idle_m = 1; done_c = 0; to_c = 0; ack_nxt = 0; to_nxt = 0; pend = 0; vc_m = 0;
    acc_wr = 0; cnt = 0; owner_m = 0; wait_k = 0; lat = 1; n_to = 0;
    exp_ram = 16'h0000;
    for (int i = 0; i < 3; i++) begin n_ack[i] = 0; hold[i] = 0; end
    grants.delete();
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    reset = 1; vid_req = 0; cpu_req = 0; mdv_req = 0; sd_done = 0;
    @(negedge clk);
    chk("rst_vid_ack", vid_ack, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_mdv_ack", mdv_ack, 0);
    chk("rst_sd_start", sd_start, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ram_data", ram_data, 16'h0000);
    chk("rst_sd_addr", sd_addr, 0);
    chk("rst_sd_we", sd_we, 0);
    chk("rst_sd_ds", sd_ds, 2'b11);
    chk("rst_sd_dout", sd_dout, 0);
    chk("rst_video_cycle", video_cycle, 0);
    @(negedge clk);
    reset = 0;
    sd_done = stray;
    sd_din = 16'h1357;
    model_init();
  endtask

  // One clock of checking and driving, entered at each falling edge.
  task automatic step();
    bit          any, exp_start, idle_new, mdv_ack_prev;
    int          w, r, dropped;
    logic [24:0] exp_addr;
    @(negedge clk);
    any          = vid_req | cpu_req | mdv_req;
    exp_start    = idle_m && any;
    idle_new     = done_c || (idle_m && !any);
    mdv_ack_prev = done_c && (owner_m == 2);
    w = 2;
    if (vid_req) w = 0;
    else if (mdv_req && cnt >= MDV_MAX_WAIT) w = 2;
    else if (cpu_req) w = 1;
    if (!mdv_req || mdv_ack_prev) cnt = 0;
    else if (owner_m != 2 && cnt < 15) cnt++;

    chk("sd_start", sd_start, exp_start);
    if (exp_start) begin
      owner_m = w;
      vc_m = (w == 0);
      grants.push_back(w);
      exp_addr = (w == 0) ? vid_addr : (w == 1) ? cpu_addr : mdv_addr;
      chk("sd_addr", sd_addr, exp_addr);
      chk("sd_we", sd_we, (w == 1) ? cpu_wr : 1'b0);
      chk("sd_ds", sd_ds, (w == 1) ? cpu_ds : 2'b00);
      if (w == 1 && cpu_wr) chk("sd_dout", sd_dout, cpu_din);
      last_we = sd_we; last_ds = sd_ds; last_dout = sd_dout;
      acc_wr = (w == 1) && cpu_wr;
      pend = 1; wait_k = 0;
      if (force_lat >= 0) lat = force_lat;
      else begin
        r = $urandom_range(0, 19);
        lat = (r < 14) ? (1 + r % 4) : (r < 17) ? TIMEOUT : (r < 18) ? TIMEOUT - 1 : 40;
      end
    end

    done_c = ack_nxt; to_c = to_nxt;
    if (done_c) begin
      if (to_c) exp_ram = 16'hFFFF;
      else if (!acc_wr) exp_ram = rdata;
      n_ack[owner_m]++;
      if (to_c) n_to++;
    end
    chk("vid_ack", vid_ack, done_c && owner_m == 0);
    chk("cpu_ack", cpu_ack, done_c && owner_m == 1);
    chk("mdv_ack", mdv_ack, done_c && owner_m == 2);
    chk("timeout_err", timeout_err, done_c && to_c);
    chk("ram_data", ram_data, exp_ram);
    chk("video_cycle", video_cycle, vc_m);

    // memory controller
    ack_nxt = 0; to_nxt = 0; sd_done = 0;
    if (pend && !exp_start) begin
      wait_k++;
      if (wait_k == lat) begin
        rdata = (force_data >= 0) ? force_data[15:0] : 16'($urandom);
        sd_din = rdata; sd_done = 1; ack_nxt = 1; pend = 0;
      end else if (wait_k == TIMEOUT) begin
        ack_nxt = 1; to_nxt = 1; pend = 0;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      sd_done = 1; sd_din = 16'($urandom);
    end

    // requesters
    dropped = -1;
    if (done_c && !hold[owner_m]) begin
      dropped = owner_m;
      case (owner_m)
        0: vid_req = 0;
        1: cpu_req = 0;
        default: mdv_req = 0;
      endcase
    end
    if (rnd_drive) begin
      if (!vid_req && dropped != 0 && $urandom_range(0, 5) == 0) begin
        vid_req = 1; vid_addr = {2'b00, 23'($urandom)};
      end
      if (!cpu_req && dropped != 1 && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_addr = {2'b01, 23'($urandom)};
        cpu_wr = 1'($urandom); cpu_ds = 2'($urandom); cpu_din = 16'($urandom);
      end
      if (!mdv_req && dropped != 2 && $urandom_range(0, 3) == 0) begin
        mdv_req = 1; mdv_addr = {2'b10, 23'($urandom)};
      end
    end
    idle_m = idle_new;
  endtask

  task automatic run_idle(input int maxc);
    int k;
    k = 0;
    while (!quiet() && k < maxc) begin step(); k++; end
    chk("drain_bound", quiet(), 1);
  endtask

  task automatic cpu_access(input bit wr, input logic [24:0] a, input logic [1:0] ds, input logic [15:0] d);
    cpu_req = 1; cpu_wr = wr; cpu_addr = a; cpu_ds = ds; cpu_din = d;
  endtask

  initial begin
    rnd_drive = 0; stray_en = 0; force_lat = -1; force_data = -1;
    model_init();

    // single CPU read, data two clocks after sd_start
    do_reset(0);
    force_lat = 2; force_data = 16'hBEEF;
    cpu_access(0, 25'h0_1234, 2'b01, 16'h0000);
    step();
    chk("read_start_latency", sd_start, 1);
    run_idle(50);
    chk("read_cpu_acks", n_ack[1], 1);
    chk("read_vid_acks", n_ack[0], 0);
    chk("read_mdv_acks", n_ack[2], 0);
    chk("read_ram_data", ram_data, 16'hBEEF);

    // three simultaneous requests
    do_reset(0);
    force_lat = 1; force_data = -1;
    vid_req = 1; vid_addr = 25'h000_0100;
    mdv_req = 1; mdv_addr = 25'h100_0200;
    cpu_access(0, 25'h080_0300, 2'b00, 16'h0000);
    run_idle(100);
    chk("tri_grants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("tri_first", grants[0], 0);
      chk("tri_second", grants[1], 1);
      chk("tri_third", grants[2], 2);
    end

    // CPU held continuously, mdv must break in once starved
    do_reset(0);
    force_lat = 1;
    cpu_access(0, 25'h080_0040, 2'b00, 16'h0000);
    mdv_req = 1; mdv_addr = 25'h100_0044;
    hold[1] = 1; hold[2] = 1;
    for (int k = 0; k < 200 && grants.size() < 4; k++) step();
    chk("starve_grants", grants.size(), 4);
    if (grants.size() == 4) begin
      chk("starve_g0", grants[0], 1);
      chk("starve_g1", grants[1], 1);
      chk("starve_g2", grants[2], 2);
      chk("starve_g3_after_clear", grants[3], 1);
    end
    hold[1] = 0; hold[2] = 0; cpu_req = 0; mdv_req = 0;
    run_idle(100);

    // sd_done on the last WAIT clock beats the watchdog
    force_lat = TIMEOUT; force_data = 16'h1234;
    cpu_access(0, 25'h080_0050, 2'b00, 16'h0000);
    run_idle(100);
    chk("edge_no_timeout", n_to, 0);
    chk("edge_ram_data", ram_data, 16'h1234);

    // watchdog
    force_lat = 99;
    cpu_access(0, 25'h080_0060, 2'b00, 16'h0000);
    run_idle(100);
    chk("wd_count", n_to, 1);
    chk("wd_ram_data", ram_data, 16'hFFFF);

    // CPU write leaves ram_data alone
    force_lat = 3; force_data = 16'h0F0F;
    cpu_access(1, 25'h080_0070, 2'b10, 16'h55AA);
    run_idle(100);
    chk("wr_sd_we", last_we, 1);
    chk("wr_sd_ds", last_ds, 2'b10);
    chk("wr_sd_dout", last_dout, 16'h55AA);
    chk("wr_ram_kept", ram_data, 16'hFFFF);

    // reset in WAIT, late sd_done is ignored
    force_lat = 99;
    cpu_access(0, 25'h080_0080, 2'b00, 16'h0000);
    for (int k = 0; k < 20 && !(pend && wait_k >= 3); k++) step();
    chk("rst_reached_wait", pend && wait_k >= 3, 1);
    do_reset(1);
    for (int k = 0; k < 20; k++) step();
    chk("rst_no_ack", n_ack[0] + n_ack[1] + n_ack[2], 0);
    force_lat = 1; force_data = 16'h0BAD;
    cpu_access(0, 25'h080_0090, 2'b00, 16'h0000);
    run_idle(50);
    chk("rst_next_ack", n_ack[1], 1);
    chk("rst_next_data", ram_data, 16'h0BAD);

    // random traffic
    do_reset(0);
    force_lat = -1; force_data = -1; rnd_drive = 1; stray_en = 1;
    for (int k = 0; k < 3000; k++) step();
    rnd_drive = 0;
    run_idle(400);
    chk("rand_progress", (n_ack[0] > 0) && (n_ack[1] > 0) && (n_ack[2] > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
